// File: rtl/row_encoder_scheduler.sv
// ============================================================================
// Module   : row_encoder_scheduler
// Purpose  : Round-robin arbiter sharing one row encoder between NUM_ROWS
//            sources; owns the timestamp counter. Optional zero-word skipping
//            is enabled by defining ROW_SCHED_ZERO_SKIP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module row_encoder_scheduler #(
    parameter int NUM_ROWS = 4,
    parameter int PIX_W    = 30,
    parameter int TS_W     = 30,
    localparam int GW      = $clog2(NUM_ROWS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      ts_clear,
    input  logic [NUM_ROWS-1:0]       row_req,
    input  logic [NUM_ROWS*PIX_W-1:0] row_pixels,
    output logic [NUM_ROWS-1:0]       row_ack,
    output logic                      enc_data_valid,
    output logic [PIX_W-1:0]          enc_pixel_in,
    output logic [TS_W-1:0]           enc_tik_tok,
    output logic [GW-1:0]             grant_id,
    output logic                      busy,
    output logic [15:0]               skip_count
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam logic [GW:0]   c_num        = (GW+1)'(NUM_ROWS);
    localparam logic [GW-1:0] c_last_reset = GW'(NUM_ROWS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_issue;
    logic                w_send;
    logic                w_zero;
    logic                w_found;
    logic [GW-1:0]       w_grant;
    logic [GW:0]         w_cand;
    logic [TS_W-1:0]     w_ts_inc;
    logic [PIX_W-1:0]    w_row_pix [NUM_ROWS];

    logic [NUM_ROWS-1:0] r_row_ack;
    logic                r_valid;
    logic [PIX_W-1:0]    r_pixel;
    logic [TS_W-1:0]     r_tik_tok;
    logic [TS_W-1:0]     r_ts;
    logic [GW-1:0]       r_grant_id;
    logic [GW-1:0]       r_last_grant;

    for (genvar i = 0; i < NUM_ROWS; i++) begin : g_unpack
        assign w_row_pix[i] = row_pixels[i*PIX_W +: PIX_W];
    end

    // Search starts one past the last winner and wraps modulo NUM_ROWS
    always_comb begin
        w_found = 1'b0;
        w_grant = r_last_grant;
        w_cand  = '0;
        for (int i = 1; i <= NUM_ROWS; i++) begin
            w_cand = {1'b0, r_last_grant} + (GW+1)'(i);
            if (w_cand >= c_num) begin
                w_cand = w_cand - c_num;
            end
            if (!w_found && row_req[w_cand[GW-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_cand[GW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable && w_found) begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef ROW_SCHED_ZERO_SKIP_EN
    assign w_zero = (w_row_pix[w_grant] == '0);
`else
    assign w_zero = 1'b0;
`endif

    assign w_send   = w_issue & ~w_zero;
    // A clear coinciding with an issue restarts the count, so the word carries 1
    assign w_ts_inc = (ts_clear ? '0 : r_ts) + TS_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_ack    <= '0;
            r_valid      <= 1'b0;
            r_pixel      <= '0;
            r_tik_tok    <= '0;
            r_ts         <= '0;
            r_grant_id   <= '0;
            r_last_grant <= c_last_reset;
        end else begin
            r_row_ack <= '0;
            r_valid   <= 1'b0;
            if (w_issue) begin
                r_row_ack    <= NUM_ROWS'(1) << w_grant;
                r_grant_id   <= w_grant;
                r_last_grant <= w_grant;
            end
            if (w_send) begin
                r_valid   <= 1'b1;
                r_pixel   <= w_row_pix[w_grant];
                r_ts      <= w_ts_inc;
                r_tik_tok <= w_ts_inc;
            end else if (ts_clear) begin
                r_ts <= '0;
            end
        end
    end

`ifdef ROW_SCHED_ZERO_SKIP_EN
    logic [15:0] r_skip_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skip_count <= '0;
        end else if (w_issue && w_zero && (r_skip_count != 16'hFFFF)) begin
            r_skip_count <= r_skip_count + 16'd1;
        end
    end

    assign skip_count = r_skip_count;
`else
    assign skip_count = 16'd0;
`endif

    assign row_ack        = r_row_ack;
    assign enc_data_valid = r_valid;
    assign enc_pixel_in   = r_pixel;
    assign enc_tik_tok    = r_tik_tok;
    assign grant_id       = r_grant_id;
    assign busy           = (r_state == S_HOLD);

endmodule

`default_nettype wire
